// File: rtl/demux_1to8_sched.sv
// Sequencing controller for a 1:8 demultiplexer: one-entry output register, addressed or round-robin routing.
// Optional HOLD timeout with discard is built when DEMUX_TIMEOUT_EN is defined.
module demux_1to8_sched #(
    parameter int DW        = 8,
    parameter int TO_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    in_sel,
    input  logic          auto_en,
    output logic [7:0]    out_valid,
    input  logic [7:0]    out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    cur_sel,
    output logic          busy,
    output logic          drop
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_data;
    logic [2:0]    r_held_sel;
    logic [2:0]    r_rr_ptr;
    logic [7:0]    r_out_valid;

    logic          w_hs;
    logic          w_load;
    logic [2:0]    w_sel;

    // Ready passes straight through from the held channel so back-to-back words see no bubble.
    assign w_hs      = (r_state == HOLD) && out_ready[r_held_sel];
    assign in_ready  = (r_state == IDLE) || w_hs;
    assign w_load    = in_valid && in_ready;
    assign w_sel     = auto_en ? r_rr_ptr : in_sel;

    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign busy      = (r_state == HOLD);
    assign cur_sel   = (r_state == HOLD) ? r_held_sel : r_rr_ptr;

`ifdef DEMUX_TIMEOUT_EN
    localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

    logic [CW-1:0] r_to_cnt;
    logic          r_drop;
    logic          w_expire;

    // The limit is reached on the TO_CYCLES-th consecutive stalled cycle; a handshake that cycle wins.
    assign w_expire = (r_state == HOLD) && !w_hs && (r_to_cnt == CW'(TO_CYCLES - 1));
    assign drop     = r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_held_sel  <= 3'd0;
            r_rr_ptr    <= 3'd0;
            r_out_valid <= 8'h00;
            r_to_cnt    <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_load) begin
                r_state     <= HOLD;
                r_data      <= in_data;
                r_held_sel  <= w_sel;
                r_out_valid <= 8'h01 << w_sel;
                r_to_cnt    <= '0;
                if (auto_en) begin
                    r_rr_ptr <= r_rr_ptr + 3'd1;
                end
            end else if (w_hs) begin
                r_state     <= IDLE;
                r_out_valid <= 8'h00;
                r_to_cnt    <= '0;
            end else if (w_expire) begin
                r_state     <= IDLE;
                r_out_valid <= 8'h00;
                r_to_cnt    <= '0;
                r_drop      <= 1'b1;
            end else if (r_state == HOLD) begin
                r_to_cnt <= r_to_cnt + CW'(1);
            end
        end
    end
`else
    assign drop = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_held_sel  <= 3'd0;
            r_rr_ptr    <= 3'd0;
            r_out_valid <= 8'h00;
        end else begin
            if (w_load) begin
                r_state     <= HOLD;
                r_data      <= in_data;
                r_held_sel  <= w_sel;
                r_out_valid <= 8'h01 << w_sel;
                if (auto_en) begin
                    r_rr_ptr <= r_rr_ptr + 3'd1;
                end
            end else if (w_hs) begin
                r_state     <= IDLE;
                r_out_valid <= 8'h00;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1to8_sched.sv
// Self-checking bench for demux_1to8_sched: vector table plus hand sequences for round-robin,
// reset during HOLD and (when DEMUX_TIMEOUT_EN is defined) the timeout discard.
module tb_demux_1to8_sched;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       auto_en;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] out_data;
    logic [2:0] cur_sel;
    logic       busy;
    logic       drop;

    int nChecks;
    int nFails;

    demux_1to8_sched #(.DW(8), .TO_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .auto_en   (auto_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .drop      (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       iv;
        logic [7:0] data;
        logic [2:0] sel;
        logic       aen;
        logic [7:0] ordy;
        logic [7:0] eov;
        logic [7:0] eod;
        logic       chkd;
        logic       eirdy;
        logic [2:0] ecur;
        logic       ebusy;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] data, input logic [2:0] sel,
                                 input logic aen, input logic [7:0] ordy);
        in_valid  = iv;
        in_data   = data;
        in_sel    = sel;
        in_auto(aen);
        out_ready = ordy;
    endtask

    task automatic in_auto(input logic aen);
        auto_en = aen;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;

        // Rows: stimulus held for one cycle, expected outputs sampled in that same cycle.
        vecs[0]  = '{1'b1, 8'hA5, 3'd5, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 8'h20, 8'hA5, 1'b1, 1'b1, 3'd5, 1'b1};
        vecs[2]  = '{1'b1, 8'h3C, 3'd3, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 8'h77, 3'd0, 1'b0, 8'h00, 8'h08, 8'h3C, 1'b1, 1'b0, 3'd3, 1'b1};
        vecs[4]  = '{1'b1, 8'h77, 3'd0, 1'b0, 8'h00, 8'h08, 8'h3C, 1'b1, 1'b0, 3'd3, 1'b1};
        vecs[5]  = '{1'b1, 8'h77, 3'd0, 1'b0, 8'h00, 8'h08, 8'h3C, 1'b1, 1'b0, 3'd3, 1'b1};
        vecs[6]  = '{1'b1, 8'h77, 3'd0, 1'b0, 8'h00, 8'h08, 8'h3C, 1'b1, 1'b0, 3'd3, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 3'd0, 1'b0, 8'h08, 8'h08, 8'h3C, 1'b1, 1'b1, 3'd3, 1'b1};
        vecs[8]  = '{1'b1, 8'h5A, 3'd2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 3'd0, 1'b0, 8'hFB, 8'h04, 8'h5A, 1'b1, 1'b0, 3'd2, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 3'd0, 1'b0, 8'hFB, 8'h04, 8'h5A, 1'b1, 1'b0, 3'd2, 1'b1};
        vecs[11] = '{1'b1, 8'hC3, 3'd6, 1'b0, 8'h04, 8'h04, 8'h5A, 1'b1, 1'b1, 3'd2, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h40, 8'hC3, 1'b1, 1'b0, 3'd6, 1'b1};

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h00);
        checkOutput("rst_out_data",  32'(out_data),  32'h00);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_drop",      32'(drop),      32'h0);
        checkOutput("rst_cur_sel",   32'(cur_sel),   32'h0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'h1);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].data, vecs[i].sel, vecs[i].aen, vecs[i].ordy);
            settle();
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            if (vecs[i].chkd) begin
                checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].eod));
            end
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eirdy));
            checkOutput($sformatf("vec%0d_cur_sel", i),  32'(cur_sel),  32'(vecs[i].ecur));
            checkOutput($sformatf("vec%0d_busy", i),     32'(busy),     32'(vecs[i].ebusy));
            checkOutput($sformatf("vec%0d_drop", i),     32'(drop),     32'h0);
            tick();
        end

        // Drain the ch6 word, then stream ten words in auto mode with in_sel held at a decoy value.
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 3'd7, 1'b1, 8'hFF);
            settle();
            checkOutput($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'h1);
            if (i > 0) begin
                checkOutput($sformatf("rr%0d_out_valid", i), 32'(out_valid), 32'(8'h01 << ((i - 1) % 8)));
                checkOutput($sformatf("rr%0d_out_data", i),  32'(out_data),  32'(8'h10 + i - 1));
            end
            tick();
        end
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, 8'hFF);
        settle();
        checkOutput("rr_last_out_valid", 32'(out_valid), 32'h02);
        checkOutput("rr_last_out_data",  32'(out_data),  32'h19);
        tick();
        settle();
        checkOutput("rr_idle_out_valid", 32'(out_valid), 32'h00);
        checkOutput("rr_idle_cur_sel",   32'(cur_sel),   32'h2);
        checkOutput("rr_idle_busy",      32'(busy),      32'h0);

        // Addressed word must not move the round-robin pointer.
        tick();
        applyStimulus(1'b1, 8'hE7, 3'd7, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        settle();
        checkOutput("addr_out_valid", 32'(out_valid), 32'h80);
        checkOutput("addr_cur_sel",   32'(cur_sel),   32'h7);
        checkOutput("addr_in_ready",  32'(in_ready),  32'h0);
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h80);
        settle();
        checkOutput("addr_hs_in_ready", 32'(in_ready), 32'h1);
        tick();
        settle();
        checkOutput("addr_idle_cur_sel", 32'(cur_sel), 32'h2);
        tick();
        applyStimulus(1'b1, 8'h42, 3'd5, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        settle();
        checkOutput("auto_out_valid", 32'(out_valid), 32'h04);
        checkOutput("auto_out_data",  32'(out_data),  32'h42);
        checkOutput("auto_cur_sel",   32'(cur_sel),   32'h2);

        // Asynchronous reset while a word is held: outputs clear before the next edge.
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h00);
        checkOutput("midrst_busy",      32'(busy),      32'h0);
        checkOutput("midrst_cur_sel",   32'(cur_sel),   32'h0);
        checkOutput("midrst_in_ready",  32'(in_ready),  32'h1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h99, 3'd4, 1'b1, 8'hFF);
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
        settle();
        checkOutput("postrst_out_valid", 32'(out_valid), 32'h01);
        checkOutput("postrst_out_data",  32'(out_data),  32'h99);
        tick();

`ifdef DEMUX_TIMEOUT_EN
        // ch1 stalls for exactly TO_CYCLES held cycles; the word is then discarded.
        applyStimulus(1'b1, 8'hD1, 3'd1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            settle();
            checkOutput($sformatf("to%0d_out_valid", k), 32'(out_valid), 32'h02);
            checkOutput($sformatf("to%0d_drop", k),      32'(drop),      32'h0);
            tick();
        end
        settle();
        checkOutput("to_drop_pulse",     32'(drop),      32'h1);
        checkOutput("to_drop_out_valid", 32'(out_valid), 32'h00);
        checkOutput("to_drop_cur_sel",   32'(cur_sel),   32'h1);
        tick();
        settle();
        checkOutput("to_drop_clear",     32'(drop),      32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
